gaussian_window_sched: RTL

Sequences a raster pixel stream into 5x5 windows for the op_gaussian datapath. It owns four line buffers, the 5x5 window register and the frame scan, and drives the operator's x/y/in inputs. It also tracks the operator's 1-cycle registered output with a valid/ready/last handshake. Sits between the pixel source FIFO and the Gaussian operator in the sobel pipeline; the operator's out bus goes straight to the consumer.

---
 rtl/gaussian_window_sched.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/gaussian_window_sched.sv
// Raster-to-5x5 window sequencer for op_gaussian: line buffers, window register,
// padded frame scan, and valid/ready/last tracking of the operator's registered output.
module gaussian_window_sched #(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int DWIDTH     = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [DWIDTH-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [25*DWIDTH-1:0]          win_data,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_y,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int XW       = $clog2(IMG_WIDTH);
  localparam int YW       = $clog2(IMG_HEIGHT);
  localparam int CXW      = $clog2(IMG_WIDTH + 2);
  localparam int CYW      = $clog2(IMG_HEIGHT + 2);
  localparam int LB_DEPTH = IMG_WIDTH + 2;
  localparam int WINW     = 25 * DWIDTH;

  localparam logic [CXW-1:0] CX_IMG  = CXW'(IMG_WIDTH);
  localparam logic [CYW-1:0] CY_IMG  = CYW'(IMG_HEIGHT);
  localparam logic [CXW-1:0] CX_LAST = CXW'(IMG_WIDTH + 1);
  localparam logic [CYW-1:0] CY_LAST = CYW'(IMG_HEIGHT + 1);
  localparam logic [XW-1:0]  X_LAST  = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0]  Y_LAST  = YW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [CXW-1:0]    cx;
  logic [CYW-1:0]    cy;
  logic [DWIDTH-1:0] lb0 [LB_DEPTH];
  logic [DWIDTH-1:0] lb1 [LB_DEPTH];
  logic [DWIDTH-1:0] lb2 [LB_DEPTH];
  logic [DWIDTH-1:0] lb3 [LB_DEPTH];

  logic [WINW-1:0]   win_q;
  logic [XW-1:0]     s1_x;
  logic [YW-1:0]     s1_y;
  logic              win_valid;

  logic [WINW-1:0]   hold_win;
  logic [XW-1:0]     hold_x;
  logic [YW-1:0]     hold_y;

  logic              is_real;
  logic              last_pos;
  logic              adv;
  logic              step;
  logic [DWIDTH-1:0] new_pix;
  logic [5*DWIDTH-1:0] new_col;

  assign is_real  = (cx < CX_IMG) && (cy < CY_IMG);
  assign last_pos = (cx == CX_LAST) && (cy == CY_LAST);
  assign adv      = !out_valid || out_ready;
  assign step     = (state == RUN) && adv && (!is_real || in_valid);
  assign in_ready = (state == RUN) && adv && is_real;
  assign new_pix  = is_real ? in_data : '0;
  // dy=+2 (newest row) sits in the top byte of the column
  assign new_col  = {new_pix, lb0[cx], lb1[cx], lb2[cx], lb3[cx]};

  // The operator registers its inputs every cycle, so while its output is stalled
  // it must keep seeing the window it already holds, not the one queued behind it.
  assign win_data = adv ? win_q : hold_win;
  assign win_x    = adv ? s1_x  : hold_x;
  assign win_y    = adv ? s1_y  : hold_y;

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (step && last_pos) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if ((out_valid && out_ready && out_last) || (!win_valid && !out_valid))
          state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cx    <= '0;
      cy    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        cx <= '0;
        cy <= '0;
      end else if (step) begin
        if (cx == CX_LAST) begin
          cx <= '0;
          cy <= cy + CYW'(1);
        end else begin
          cx <= cx + CXW'(1);
        end
      end
    end
  end

  // Line buffer contents need no reset; rows from a previous frame only reach out-of-bounds taps.
  always_ff @(posedge clock) begin
    if (step) begin
      lb3[cx] <= lb2[cx];
      lb2[cx] <= lb1[cx];
      lb1[cx] <= lb0[cx];
      lb0[cx] <= new_pix;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      win_q     <= '0;
      s1_x      <= '0;
      s1_y      <= '0;
      win_valid <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      hold_win  <= '0;
      hold_x    <= '0;
      hold_y    <= '0;
    end else begin
      if (step) begin
        win_q     <= {new_col, win_q[WINW-1:5*DWIDTH]};
        win_valid <= (cx >= CXW'(2)) && (cy >= CYW'(2));
        s1_x      <= XW'(cx - CXW'(2));
        s1_y      <= YW'(cy - CYW'(2));
      end else if (adv) begin
        win_valid <= 1'b0;
      end
      if (adv) begin
        out_valid <= win_valid;
        out_last  <= win_valid && (s1_x == X_LAST) && (s1_y == Y_LAST);
      end
      hold_win <= win_data;
      hold_x   <= win_x;
      hold_y   <= win_y;
    end
  end

endmodule
